// File: rtl/interrupt_pending_gen.sv
// Machine interrupt-pending vector generator: mtime/mtimecmp timer, MSIP,
// synchronised external IRQs and S-mode software-writable pending bits.
module interrupt_pending_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ext_m_irq,
  input  logic        i_ext_s_irq,
  input  logic        i_mip_we,
  input  logic [11:0] i_mip_wdata,
  input  logic        i_bus_valid,
  input  logic        i_bus_we,
  input  logic [2:0]  i_bus_addr,
  input  logic [31:0] i_bus_wdata,
  output logic        o_bus_ready,
  output logic        o_rdata_valid,
  output logic [31:0] o_rdata,
  output logic [11:0] o_intp
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_bus_ready;
  logic                   w_bus_ready_next;
  logic                   r_rdata_valid;
  logic                   w_rdata_valid_next;
  logic [31:0]            r_rdata;
  logic [31:0]            w_rdata_next;
  logic                   w_accept;
  logic                   w_wr;
  logic [31:0]            w_rd_mux;

  logic [63:0]            r_mtime;
  logic [63:0]            r_mtimecmp;
  logic [63:0]            w_mtime_next;
  logic [63:0]            w_mtimecmp_next;
  logic [PW-1:0]          r_presc;
  logic [PW-1:0]          w_presc_next;
  logic                   w_tick;
  logic                   r_mtip;

  logic                   r_msip;
  logic                   r_ssip;
  logic                   r_stip;
  logic                   r_seip_sw;
  logic [SYNC_STAGES-1:0] r_sync_m;
  logic [SYNC_STAGES-1:0] r_sync_s;
  logic                   w_unused_mip;

  assign w_unused_mip = ^{i_mip_wdata[11:10], i_mip_wdata[8:6], i_mip_wdata[4:2], i_mip_wdata[0]};

  // Read-data source, sampled from the current (pre-tick) register values
  always_comb begin
    w_rd_mux = 32'd0;
    case (i_bus_addr)
      3'd0:    w_rd_mux = {31'd0, r_msip};
      3'd2:    w_rd_mux = r_mtimecmp[31:0];
      3'd3:    w_rd_mux = r_mtimecmp[63:32];
      3'd4:    w_rd_mux = r_mtime[31:0];
      3'd5:    w_rd_mux = r_mtime[63:32];
      default: w_rd_mux = 32'd0;
    endcase
  end

  // Bus FSM next state and registered handshake outputs
  always_comb begin
    w_state_next       = r_state;
    w_accept           = 1'b0;
    w_rdata_valid_next = 1'b0;
    w_rdata_next       = 32'd0;
    case (r_state)
      ST_IDLE: begin
        w_accept = i_bus_valid && r_bus_ready;
        if (w_accept && !i_bus_we) begin
          w_state_next       = ST_RESP;
          w_rdata_valid_next = 1'b1;
          w_rdata_next       = w_rd_mux;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    w_bus_ready_next = (w_state_next == ST_IDLE);
    w_wr             = w_accept && i_bus_we;
  end

  // Timer next values; a bus write replaces only its half, without carry
  always_comb begin
    w_tick          = (r_presc == PRESC_MAX);
    w_presc_next    = w_tick ? {PW{1'b0}} : r_presc + {{(PW-1){1'b0}}, 1'b1};
    w_mtime_next    = w_tick ? r_mtime + 64'd1 : r_mtime;
    w_mtimecmp_next = r_mtimecmp;
    if (w_wr) begin
      case (i_bus_addr)
        3'd2:    w_mtimecmp_next = {r_mtimecmp[63:32], i_bus_wdata};
        3'd3:    w_mtimecmp_next = {i_bus_wdata, r_mtimecmp[31:0]};
        3'd4:    w_mtime_next    = {r_mtime[63:32], i_bus_wdata};
        3'd5:    w_mtime_next    = {i_bus_wdata, r_mtime[31:0]};
        default: w_mtime_next    = w_mtime_next;
      endcase
    end else begin
      w_mtimecmp_next = r_mtimecmp;
    end
  end

  // Bus FSM state and response registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_bus_ready   <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata       <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_bus_ready   <= w_bus_ready_next;
      r_rdata_valid <= w_rdata_valid_next;
      r_rdata       <= w_rdata_next;
    end
  end

  // Timer, pending-bit and synchroniser registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= {64{1'b1}};
      r_presc    <= {PW{1'b0}};
      r_mtip     <= 1'b0;
      r_msip     <= 1'b0;
      r_ssip     <= 1'b0;
      r_stip     <= 1'b0;
      r_seip_sw  <= 1'b0;
      r_sync_m   <= {SYNC_STAGES{1'b0}};
      r_sync_s   <= {SYNC_STAGES{1'b0}};
    end else begin
      r_mtime    <= w_mtime_next;
      r_mtimecmp <= w_mtimecmp_next;
      r_presc    <= w_presc_next;
      r_mtip     <= (w_mtime_next >= w_mtimecmp_next);
      if (w_wr && (i_bus_addr == 3'd0)) begin
        r_msip <= i_bus_wdata[0];
      end
      if (i_mip_we) begin
        r_ssip    <= i_mip_wdata[1];
        r_stip    <= i_mip_wdata[5];
        r_seip_sw <= i_mip_wdata[9];
      end
      r_sync_m <= {r_sync_m[SYNC_STAGES-2:0], i_ext_m_irq};
      r_sync_s <= {r_sync_s[SYNC_STAGES-2:0], i_ext_s_irq};
    end
  end

  assign o_bus_ready   = r_bus_ready;
  assign o_rdata_valid = r_rdata_valid;
  assign o_rdata       = r_rdata;
  assign o_intp        = {r_sync_m[SYNC_STAGES-1], 1'b0,
                          r_seip_sw | r_sync_s[SYNC_STAGES-1], 1'b0,
                          r_mtip, 1'b0, r_stip, 1'b0, r_msip, 1'b0, r_ssip, 1'b0};

endmodule

// File: tb/tb_interrupt_pending_gen.sv
// Self-checking bench for interrupt_pending_gen: directed scenarios plus a
// randomized run, all checked against a behavioural model of the pending vector.
module tb_interrupt_pending_gen;

  localparam int SYNC_STAGES = 2;
  localparam int PRESCALE    = 1;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_ext_m_irq = 1'b0;
  logic        i_ext_s_irq = 1'b0;
  logic        i_mip_we = 1'b0;
  logic [11:0] i_mip_wdata = 12'd0;
  logic        i_bus_valid = 1'b0;
  logic        i_bus_we = 1'b0;
  logic [2:0]  i_bus_addr = 3'd0;
  logic [31:0] i_bus_wdata = 32'd0;
  logic        o_bus_ready;
  logic        o_rdata_valid;
  logic [31:0] o_rdata;
  logic [11:0] o_intp;

  always #5 i_clk = ~i_clk;

  interrupt_pending_gen #(.SYNC_STAGES(SYNC_STAGES), .PRESCALE(PRESCALE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ext_m_irq(i_ext_m_irq), .i_ext_s_irq(i_ext_s_irq),
    .i_mip_we(i_mip_we), .i_mip_wdata(i_mip_wdata), .i_bus_valid(i_bus_valid),
    .i_bus_we(i_bus_we), .i_bus_addr(i_bus_addr), .i_bus_wdata(i_bus_wdata),
    .o_bus_ready(o_bus_ready), .o_rdata_valid(o_rdata_valid), .o_rdata(o_rdata),
    .o_intp(o_intp)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_ssip, m_stip, m_seip_sw, m_sync_m, m_sync_s;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;
  longint      m_edges;
  bit          q_m[$];
  bit          q_s[$];

  task automatic model_reset();
    m_mtime = 64'd0; m_cmp = {64{1'b1}};
    m_msip = 1'b0; m_ssip = 1'b0; m_stip = 1'b0; m_seip_sw = 1'b0;
    m_sync_m = 1'b0; m_sync_s = 1'b0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0; m_edges = 0;
    q_m.delete(); q_s.delete();
    for (int k = 0; k < SYNC_STAGES - 1; k++) begin
      q_m.push_back(1'b0); q_s.push_back(1'b0);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0: return {31'd0, m_msip};
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return m_mtime[31:0];
      3'd5: return m_mtime[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [11:0] exp_intp();
    logic [11:0] v;
    v = 12'd0;
    v[1]  = m_ssip;
    v[3]  = m_msip;
    v[5]  = m_stip;
    v[7]  = (m_mtime >= m_cmp);
    v[9]  = m_seip_sw | m_sync_s;
    v[11] = m_sync_m;
    return v;
  endfunction

  task automatic model_edge();
    logic        tick_now, accept;
    logic [63:0] t_new, c_new;
    if (!i_rst_n) return;
    tick_now = ((m_edges % PRESCALE) == PRESCALE - 1);
    m_edges++;
    accept = i_bus_valid && m_ready;
    if (m_rvalid) begin
      m_rvalid = 1'b0; m_rdata = 32'd0; m_ready = 1'b1;
    end else if (accept && !i_bus_we) begin
      m_rdata = model_rd(i_bus_addr); m_rvalid = 1'b1; m_ready = 1'b0;
    end else begin
      m_rdata = 32'd0; m_rvalid = 1'b0; m_ready = 1'b1;
    end
    t_new = tick_now ? m_mtime + 64'd1 : m_mtime;
    c_new = m_cmp;
    if (accept && i_bus_we) begin
      case (i_bus_addr)
        3'd0: m_msip = i_bus_wdata[0];
        3'd2: c_new[31:0] = i_bus_wdata;
        3'd3: c_new[63:32] = i_bus_wdata;
        3'd4: t_new = {m_mtime[63:32], i_bus_wdata};
        3'd5: t_new = {i_bus_wdata, m_mtime[31:0]};
        default: ;
      endcase
    end
    m_mtime = t_new;
    m_cmp = c_new;
    if (i_mip_we) begin
      m_ssip = i_mip_wdata[1]; m_stip = i_mip_wdata[5]; m_seip_sw = i_mip_wdata[9];
    end
    q_m.push_back(i_ext_m_irq); m_sync_m = q_m.pop_front();
    q_s.push_back(i_ext_s_irq); m_sync_s = q_s.pop_front();
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    model_reset();
    tick(); tick();
    i_rst_n = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (!m_ready && n < 8) begin tick(); n++; end
    i_bus_valid = 1'b1; i_bus_we = 1'b1; i_bus_addr = a; i_bus_wdata = d;
    tick();
    i_bus_valid = 1'b0; i_bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    int n;
    n = 0;
    while (!m_ready && n < 8) begin tick(); n++; end
    i_bus_valid = 1'b1; i_bus_we = 1'b0; i_bus_addr = a;
    tick();
    i_bus_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (o_intp !== 12'd0) begin errors++; $display("FAIL reset_intp got %h want 000", o_intp); end
    checks++; if (o_rdata_valid !== 1'b0 || o_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got v=%b d=%h want v=0 d=0", o_rdata_valid, o_rdata); end
    checks++; if (o_bus_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_bus_ready); end
    @(negedge i_clk);
    tick();
    i_rst_n = 1'b1;
    tick();
    checks++; if (o_bus_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", o_bus_ready); end
  endtask

  task automatic test_timer_match();
    int rise_at;
    rise_at = -1;
    do_reset();
    bus_write(3'd2, 32'd10);
    bus_write(3'd3, 32'd0);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (o_intp[7] !== (m_mtime >= 64'd10)) begin
        errors++; $display("FAIL mtip_match mtime=%0d got %b want %b", m_mtime, o_intp[7], m_mtime >= 64'd10);
      end
      if (o_intp[7] === 1'b1 && rise_at < 0) rise_at = int'(m_mtime);
      tick();
    end
    checks++; if (rise_at != 10) begin errors++; $display("FAIL mtip_rise_point got mtime=%0d want 10", rise_at); end
  endtask

  task automatic test_mtime_wrap();
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_write(3'd5, 32'hFFFF_FFFF);
    checks++; if (m_mtime !== {64{1'b1}} || o_intp[7] !== 1'b1) begin errors++; $display("FAIL mtime_all_ones mtip got %b want 1", o_intp[7]); end
    tick();
    checks++; if (o_intp[7] !== 1'b0) begin errors++; $display("FAIL mtime_wrap_mtip got %b want 0", o_intp[7]); end
    bus_read(3'd5);
    checks++; if (o_rdata_valid !== 1'b1 || o_rdata !== 32'd0) begin errors++; $display("FAIL mtime_wrap_hi got v=%b d=%h want v=1 d=0", o_rdata_valid, o_rdata); end
    tick();
    bus_read(3'd4);
    checks++; if (o_rdata !== m_rdata) begin errors++; $display("FAIL mtime_lo_read got %h want %h", o_rdata, m_rdata); end
    tick();
  endtask

  task automatic test_ext_irq();
    int first_hi, highs;
    first_hi = -1; highs = 0;
    i_ext_m_irq = 1'b0;
    for (int c = 0; c < SYNC_STAGES + 1; c++) tick();
    i_ext_m_irq = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 5) i_ext_m_irq = 1'b0;
      checks++;
      if (o_intp[11] !== m_sync_m) begin errors++; $display("FAIL ext_m_level cyc=%0d got %b want %b", c, o_intp[11], m_sync_m); end
      if (o_intp[11] === 1'b1) begin
        highs++;
        if (first_hi < 0) first_hi = c;
      end
    end
    checks++; if (first_hi != SYNC_STAGES || highs != 5) begin errors++; $display("FAIL ext_m_pulse got start=%0d len=%0d want start=%0d len=5", first_hi, highs, SYNC_STAGES); end
  endtask

  task automatic test_msip_rw();
    bus_write(3'd0, 32'd1);
    checks++; if (o_intp[3] !== 1'b1) begin errors++; $display("FAIL msip_set got %b want 1", o_intp[3]); end
    bus_read(3'd0);
    checks++; if (o_rdata_valid !== 1'b1 || o_rdata !== 32'h1 || o_bus_ready !== 1'b0) begin
      errors++; $display("FAIL msip_read got v=%b d=%h rdy=%b want v=1 d=1 rdy=0", o_rdata_valid, o_rdata, o_bus_ready);
    end
    tick();
    checks++; if (o_rdata_valid !== 1'b0 || o_rdata !== 32'd0 || o_bus_ready !== 1'b1) begin
      errors++; $display("FAIL resp_end got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", o_rdata_valid, o_rdata, o_bus_ready);
    end
    bus_write(3'd6, 32'hDEAD_BEEF);
    bus_read(3'd6);
    checks++; if (o_rdata_valid !== 1'b1 || o_rdata !== 32'd0) begin errors++; $display("FAIL hole_read got v=%b d=%h want v=1 d=0", o_rdata_valid, o_rdata); end
    tick();
  endtask

  task automatic test_mip_sw();
    bus_write(3'd0, 32'd0);
    bus_write(3'd3, 32'hFFFF_FFFF);
    i_ext_s_irq = 1'b0; i_ext_m_irq = 1'b0;
    for (int c = 0; c < SYNC_STAGES; c++) tick();
    i_mip_we = 1'b1; i_mip_wdata = 12'h222;
    tick();
    i_mip_we = 1'b0;
    checks++; if (o_intp !== 12'h222 || o_intp !== exp_intp()) begin errors++; $display("FAIL mip_sw_set got %h want 222", o_intp); end
    i_ext_s_irq = 1'b1; i_mip_we = 1'b1; i_mip_wdata = 12'h000;
    tick();
    i_mip_we = 1'b0;
    for (int c = 0; c < SYNC_STAGES; c++) tick();
    checks++; if (o_intp !== 12'h200 || o_intp !== exp_intp()) begin errors++; $display("FAIL mip_sw_ext_s got %h want 200", o_intp); end
    i_ext_s_irq = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [2:0] a;
    for (int c = 0; c < 400; c++) begin
      i_ext_m_irq = 1'($urandom_range(0, 1));
      i_ext_s_irq = 1'($urandom_range(0, 1));
      i_mip_we    = ($urandom_range(0, 7) == 0);
      i_mip_wdata = 12'($urandom);
      if (m_ready && $urandom_range(0, 2) == 0) begin
        a = 3'($urandom_range(0, 7));
        i_bus_valid = 1'b1; i_bus_we = 1'($urandom_range(0, 1)); i_bus_addr = a;
        if (a == 3'd2 && $urandom_range(0, 1) == 1) i_bus_wdata = m_mtime[31:0] + 32'($urandom_range(0, 20));
        else if (a == 3'd3 || a == 3'd5) i_bus_wdata = 32'($urandom_range(0, 1));
        else i_bus_wdata = $urandom;
      end else begin
        i_bus_valid = 1'b0;
      end
      tick();
      checks++; if (o_intp !== exp_intp()) begin errors++; $display("FAIL rnd_intp cyc=%0d got %h want %h", c, o_intp, exp_intp()); end
      checks++; if (o_bus_ready !== m_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got %b want %b", c, o_bus_ready, m_ready); end
      checks++; if (o_rdata_valid !== m_rvalid || o_rdata !== m_rdata) begin
        errors++; $display("FAIL rnd_rdata cyc=%0d got v=%b d=%h want v=%b d=%h", c, o_rdata_valid, o_rdata, m_rvalid, m_rdata);
      end
    end
    i_bus_valid = 1'b0; i_mip_we = 1'b0; i_ext_m_irq = 1'b0; i_ext_s_irq = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    bus_read(3'd2);
    checks++; if (o_rdata_valid !== 1'b1) begin errors++; $display("FAIL mid_read_resp got %b want 1", o_rdata_valid); end
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (o_rdata_valid !== 1'b0 || o_rdata !== 32'd0 || o_intp !== 12'd0) begin
      errors++; $display("FAIL mid_read_reset got v=%b d=%h intp=%h want 0", o_rdata_valid, o_rdata, o_intp);
    end
    @(negedge i_clk);
    tick();
    i_rst_n = 1'b1;
    bus_read(3'd5);
    checks++; if (o_rdata !== 32'd0) begin errors++; $display("FAIL post_reset_mtime_hi got %h want 0", o_rdata); end
    tick();
    bus_read(3'd2);
    checks++; if (o_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_cmp_lo got %h want ffffffff", o_rdata); end
    tick();
    bus_read(3'd3);
    checks++; if (o_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_cmp_hi got %h want ffffffff", o_rdata); end
    tick();
    bus_read(3'd4);
    checks++; if (o_rdata !== m_rdata) begin errors++; $display("FAIL post_reset_mtime_lo got %h want %h", o_rdata, m_rdata); end
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timer_match();
    test_mtime_wrap();
    test_ext_irq();
    test_msip_rw();
    test_mip_sw();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
